dff_monitor: RTL and testbench

DFF_MONITOR -- requirements
Module: dff_monitor

---
 rtl/dff_monitor.sv | 141 ++++++++++++++
 tb/tb_dff_monitor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dff_monitor.sv
// dff_monitor -- checks an observed D flip-flop with async active-low reset
// against its expected behaviour, cycle by cycle.
//
// Parameters:
//   ERR_W : width of the error counter err_cnt
//   CHK_W : width of the checked-cycle counter chk_cnt
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high monitor reset
//   enable     : checking enabled when 1
//   clr        : synchronous clear of counters, sticky flag and err pulse
//   mon_rst_n  : observed async active-low reset of the flop under check
//   mon_d      : observed flop data input
//   mon_q      : observed flop output
//   mon_q_bar  : observed flop inverted output
//   err        : one-cycle pulse following each failing check
//   err_sticky : set on any failure, held until clr or rst
//   err_cnt    : count of failing check cycles
//   chk_cnt    : count of checked cycles (wraps)
//   state      : FSM state (IDLE=00, SETTLE=01, CHECK=10, RESET_CHK=11)
//
// Build option:
//   DFF_MON_SAT_EN : when defined, err_cnt saturates at all-ones;
//                    otherwise it wraps to zero.
module dff_monitor #(
    parameter int ERR_W = 8,
    parameter int CHK_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr,
    input  logic             mon_rst_n,
    input  logic             mon_d,
    input  logic             mon_q,
    input  logic             mon_q_bar,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CHK_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SETTLE    = 2'b01,
        CHECK     = 2'b10,
        RESET_CHK = 2'b11
    } state_t;

    state_t             state_r;
    state_t             state_nxt;
    logic               d_prev;
    logic               rst_prev;
    logic               exp_q;
    logic               chk_act;
    logic               fail;
    logic               err_r;
    logic               sticky_r;
    logic [ERR_W-1:0]   err_cnt_r;
    logic [ERR_W-1:0]   err_cnt_inc;
    logic [CHK_W-1:0]   chk_cnt_r;

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt = SETTLE;
            end
            SETTLE, CHECK, RESET_CHK: begin
                if (!enable)         state_nxt = IDLE;
                else if (!mon_rst_n) state_nxt = RESET_CHK;
                else                 state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Check evaluation. The flop is expected to read 0 while its reset is
    // asserted and on the first edge after release (rst_prev still 0);
    // otherwise it should hold the data captured on the previous edge.
    // Checking is gated by enable so that the edge leaving CHECK for IDLE
    // leaves counters untouched.
    always_comb begin
        exp_q   = (!mon_rst_n || !rst_prev) ? 1'b0 : d_prev;
        chk_act = enable && (state_r == CHECK || state_r == RESET_CHK);
        fail    = chk_act && ((mon_q != exp_q) || (mon_q_bar == mon_q));
    end

    always_comb begin
`ifdef DFF_MON_SAT_EN
        err_cnt_inc = (err_cnt_r == '1) ? err_cnt_r : err_cnt_r + ERR_W'(1);
`else
        err_cnt_inc = err_cnt_r + ERR_W'(1);
`endif
    end

    // State register and history of the observed inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            d_prev   <= 1'b0;
            rst_prev <= 1'b1;
        end else begin
            state_r  <= state_nxt;
            d_prev   <= mon_d;
            rst_prev <= mon_rst_n;
        end
    end

    // Result reporting; clr overrides a same-cycle failure
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r     <= 1'b0;
            sticky_r  <= 1'b0;
            err_cnt_r <= '0;
            chk_cnt_r <= '0;
        end else if (clr) begin
            err_r     <= 1'b0;
            sticky_r  <= 1'b0;
            err_cnt_r <= '0;
            chk_cnt_r <= '0;
        end else begin
            err_r <= fail;
            if (fail) begin
                sticky_r  <= 1'b1;
                err_cnt_r <= err_cnt_inc;
            end
            if (chk_act) chk_cnt_r <= chk_cnt_r + CHK_W'(1);
        end
    end

    assign err        = err_r;
    assign err_sticky = sticky_r;
    assign err_cnt    = err_cnt_r;
    assign chk_cnt    = chk_cnt_r;
    assign state      = state_r;

endmodule

// File: tb/tb_dff_monitor.sv
// tb_dff_monitor -- randomized and directed self-checking bench for
// dff_monitor. Two instances share the stimulus: one with default widths and
// one with ERR_W=2 to exercise err_cnt wrap/saturation quickly.
module tb_dff_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic        mon_rst_n = 1'b1;
    logic        mon_d = 1'b0;
    logic        mon_q = 1'b0;
    logic        mon_q_bar = 1'b1;

    logic        err, err_sticky;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;
    logic [1:0]  state;

    logic        err2, err_sticky2;
    logic [1:0]  err_cnt2;
    logic [15:0] chk_cnt2;
    logic [1:0]  state2;

    int total = 0;
    int bad   = 0;

    // Reference model: plain counts and history, no FSM encoding
    int          m_en_run  = 0;   // consecutive enabled edges, capped at 2
    bit          m_dprev   = 1'b0;
    bit          m_rprev   = 1'b1;
    bit          m_err     = 1'b0;
    bit          m_sticky  = 1'b0;
    int          m_fails   = 0;   // failures since last rst/clr
    int          m_checks  = 0;   // checks since last rst/clr
    int          m_state   = 0;

    dff_monitor dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .mon_rst_n(mon_rst_n), .mon_d(mon_d), .mon_q(mon_q), .mon_q_bar(mon_q_bar),
        .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .state(state)
    );

    dff_monitor #(.ERR_W(2), .CHK_W(16)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .mon_rst_n(mon_rst_n), .mon_d(mon_d), .mon_q(mon_q), .mon_q_bar(mon_q_bar),
        .err(err2), .err_sticky(err_sticky2), .err_cnt(err_cnt2),
        .chk_cnt(chk_cnt2), .state(state2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ecnt(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef DFF_MON_SAT_EN
        return (n > mx) ? mx : n;
`else
        return n & mx;
`endif
    endfunction

    // One clock: drive inputs, let the edge happen, advance model, compare.
    // fq/fqb inject faults on q and q_bar relative to a correct flop.
    task automatic step(input bit en, input bit c, input bit r, input bit rn,
                        input bit d, input bit fq, input bit fqb);
        bit good_q, q, qb, checking, fail;
        good_q    = (!rn || !m_rprev) ? 1'b0 : m_dprev;
        q         = good_q ^ fq;
        qb        = ~q ^ fqb;
        enable    = en;
        clr       = c;
        rst       = r;
        mon_rst_n = rn;
        mon_d     = d;
        mon_q     = q;
        mon_q_bar = qb;
        @(posedge clk);
        if (r) begin
            m_en_run = 0; m_dprev = 1'b0; m_rprev = 1'b1;
            m_err = 1'b0; m_sticky = 1'b0; m_fails = 0; m_checks = 0;
            m_state = 0;
        end else begin
            checking = en && (m_en_run >= 2);
            fail     = checking && ((q != good_q) || (qb == q));
            if (c) begin
                m_err = 1'b0; m_sticky = 1'b0; m_fails = 0; m_checks = 0;
            end else begin
                m_err = fail;
                if (fail) begin m_sticky = 1'b1; m_fails++; end
                if (checking) m_checks++;
            end
            m_en_run = en ? ((m_en_run >= 2) ? 2 : m_en_run + 1) : 0;
            m_dprev  = d;
            m_rprev  = rn;
            m_state  = (m_en_run == 0) ? 0 : (m_en_run == 1) ? 1 : (rn ? 2 : 3);
        end
        #1;
        check_val("state",   int'(state),      m_state);
        check_val("err",     int'(err),        int'(m_err));
        check_val("sticky",  int'(err_sticky), int'(m_sticky));
        check_val("err_cnt", int'(err_cnt),    exp_ecnt(m_fails, 8));
        check_val("chk_cnt", int'(chk_cnt),    m_checks & 16'hFFFF);
        check_val("err_cnt2", int'(err_cnt2),  exp_ecnt(m_fails, 2));
        check_val("err2",    int'(err2),       int'(m_err));
    endtask

    initial begin
        // Reset for two cycles, then enable with a correct flop, d=1,0,1
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("s1_settle", int'(state), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("s1_check", int'(state), 2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // d_prev=1: wrong q gives one err pulse
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("s2_err", int'(err), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("s2_pulse_end", int'(err), 0);
        check_val("s2_cnt", int'(err_cnt), 1);
        // Flop held in reset three cycles, then released with q wrong
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_val("s3_rstchk", int'(state), 3);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("s3_release", int'(state), 2);
        check_val("s3_err", int'(err), 1);
        // q_bar stuck equal to q
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        // clr coinciding with a failure (both q and q_bar wrong)
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("s5_cnt", int'(err_cnt), 0);
        check_val("s5_state", int'(state), 2);
        // Five consecutive failures for the narrow counter
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // Disable mid-operation, then rst priority over clr/enable/failure
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 92),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 999) < 5),
                 ($urandom_range(0, 99) >= 15),
                 1'($urandom),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 6));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
